// File: rtl/hex_enc_pkg.sv
// Shared types and widths for the hex key encoder/capture block.
package hex_enc_pkg;

    localparam int unsigned HEX_W    = 4;
    localparam int unsigned ONEHOT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

endpackage

// File: rtl/hex_encoder_capture_enc.sv
// Combinational one-hot to hex encoder: highest set index plus a multi-hot flag.
module onehot_to_hex
    import hex_enc_pkg::*;
(
    input  logic [ONEHOT_W-1:0] onehot,
    output logic [HEX_W-1:0]    code,
    output logic                multi
);

    always_comb begin
        code = '0;
        for (int unsigned i = 0; i < ONEHOT_W; i++) begin
            if (onehot[i]) code = HEX_W'(i);
        end
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi = (onehot & (onehot - ONEHOT_W'(1))) != '0;
    end

endmodule

// File: rtl/hex_encoder_capture.sv
// Debounced hex key capture: synchronises 16 key lines, debounces, encodes.
// Optional macro HEX_ENC_PRIORITY_EN: multi-hot accepts report the highest key.
module hex_encoder_capture
    import hex_enc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ONEHOT_W-1:0] onehot_in,
    output logic [HEX_W-1:0]    hex_out,
    output logic                hex_valid,
    output logic                hex_err,
    output logic                key_held
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [ONEHOT_W-1:0] sync1, s;
    logic [ONEHOT_W-1:0] cand, cand_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    state_t              state, state_n;
    logic                accept;
    logic [HEX_W-1:0]    enc_code;
    logic                enc_multi;
    logic                take_valid, take_err;

    onehot_to_hex u_enc (
        .onehot (cand),
        .code   (enc_code),
        .multi  (enc_multi)
    );

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s != '0) begin
                    cand_n  = s;
                    cnt_n   = CNT_ONE;
                    state_n = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (s == '0) begin
                    state_n = ST_IDLE;
                end else if (s == cand) begin
                    if (cnt == CNT_LAST) begin
                        state_n = ST_HELD;
                        accept  = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end else begin
                    cand_n = s;
                    cnt_n  = CNT_ONE;
                end
            end
            ST_HELD: begin
                if (s == '0) begin
                    cnt_n   = CNT_ONE;
                    state_n = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (s != '0) begin
                    state_n = ST_HELD;
                end else if (cnt == CNT_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

`ifdef HEX_ENC_PRIORITY_EN
    assign take_valid = accept;
    assign take_err   = 1'b0;
`else
    assign take_valid = accept & ~enc_multi;
    assign take_err   = accept &  enc_multi;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            s         <= '0;
            state     <= ST_IDLE;
            cand      <= '0;
            cnt       <= '0;
            hex_out   <= '0;
            hex_valid <= 1'b0;
            hex_err   <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            sync1     <= onehot_in;
            s         <= sync1;
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            hex_valid <= take_valid;
            hex_err   <= take_err;
            if (take_valid) hex_out <= enc_code;
            // Registered from next state so it tracks HELD/RELEASE cycle-for-cycle.
            key_held  <= (state_n == ST_HELD) || (state_n == ST_RELEASE);
        end
    end

endmodule
